// File: rtl/pll_reset_pkg.sv
// Shared types and constants for the PLL reset sequencer.
package pll_reset_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } seq_state_t;

    localparam int unsigned LOSS_CNT_W = 8;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Lock-in / reset-out signal group of the PLL reset sequencer.
// lock_losses exists only when PLL_LOSS_COUNT_EN is defined.
interface pll_reset_sequencer_if;
    import pll_reset_pkg::*;

    logic pll_locked;
    logic sys_reset;
    logic ready;
`ifdef PLL_LOSS_COUNT_EN
    logic [LOSS_CNT_W-1:0] lock_losses;

    modport master (input pll_locked, output sys_reset, output ready, output lock_losses);
    modport slave  (output pll_locked, input sys_reset, input ready, input lock_losses);
`else
    modport master (input pll_locked, output sys_reset, output ready);
    modport slave  (output pll_locked, input sys_reset, input ready);
`endif

endinterface

// File: rtl/pll_reset_sequencer_lock_sync.sv
// Multi-flop synchroniser for asynchronous status inputs, cleared by synchronous reset.
module lock_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clock) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], async_in};
        end
    end

    assign sync_out = chain[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Qualifies PLL lock and sequences the downstream reset; optional loss counter
// enabled by defining PLL_LOSS_COUNT_EN.
module pll_reset_sequencer
    import pll_reset_pkg::*;
#(
    parameter int unsigned SYNC_STAGES        = 2,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned RESET_HOLD_CYCLES  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    pll_reset_sequencer_if.master bus
);

    localparam int unsigned CNT_W = $clog2(max_u(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES) + 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);

    logic             lock_s;
    seq_state_t       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             sys_reset_q, ready_q;

    lock_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (bus.pll_locked),
        .sync_out (lock_s)
    );

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            WAIT_LOCK: if (lock_s) begin
                state_next = STABILIZE;
                cnt_next   = '0;
            end
            STABILIZE: if (!lock_s) begin
                state_next = WAIT_LOCK;
                cnt_next   = '0;
            end else if (cnt == STABLE_LAST) begin
                state_next = HOLD;
                cnt_next   = '0;
            end else begin
                cnt_next = cnt + 1'b1;
            end
            HOLD: if (!lock_s) begin
                state_next = WAIT_LOCK;
                cnt_next   = '0;
            end else if (cnt == HOLD_LAST) begin
                state_next = RUN;
            end else begin
                cnt_next = cnt + 1'b1;
            end
            RUN: if (!lock_s) begin
                state_next = WAIT_LOCK;
                cnt_next   = '0;
            end
            default: begin
                state_next = WAIT_LOCK;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the same edge as the FSM.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= WAIT_LOCK;
            cnt         <= '0;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            sys_reset_q <= (state_next != RUN);
            ready_q     <= (state_next == RUN);
        end
    end

    assign bus.sys_reset = sys_reset_q;
    assign bus.ready     = ready_q;

`ifdef PLL_LOSS_COUNT_EN
    logic [LOSS_CNT_W-1:0] losses;

    always_ff @(posedge clock) begin
        if (reset) begin
            losses <= '0;
        end else if (state == RUN && !lock_s && losses != '1) begin
            losses <= losses + 1'b1;
        end
    end

    assign bus.lock_losses = losses;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer (SYNC_STAGES=2, LOCK_STABLE_CYCLES=8, RESET_HOLD_CYCLES=4).
module tb_pll_reset_sequencer;

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    pll_reset_sequencer_if bus();

    pll_reset_sequencer #(
        .SYNC_STAGES        (2),
        .LOCK_STABLE_CYCLES (8),
        .RESET_HOLD_CYCLES  (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset          = 1'b1;
        bus.pll_locked = 1'b1;

        // 1: reset held for three edges; the last is edge 0
        for (int i = 0; i < 3; i++) begin
            step();
            check("t1_sys_reset", bus.sys_reset, 1);
            check("t1_ready", bus.ready, 0);
`ifdef PLL_LOSS_COUNT_EN
            check("t1_losses", bus.lock_losses, 0);
`endif
        end

        // 2: release, lock stable -> release at edge 15
        reset = 1'b0;
        for (int e = 1; e <= 14; e++) begin
            step();
            check("t2_held", bus.sys_reset, 1);
        end
        step();
        check("t2_release_sys_reset", bus.sys_reset, 0);
        check("t2_release_ready", bus.ready, 1);
        for (int e = 16; e <= 20; e++) begin
            step();
            check("t2_stay", bus.sys_reset, 0);
        end

        // 3: one-cycle lock drop after edge 20
        bus.pll_locked = 1'b0;
        step();
        bus.pll_locked = 1'b1;
        check("t3_e21", bus.sys_reset, 0);
        step();
        check("t3_e22", bus.sys_reset, 0);
        step();
        check("t3_e23_sys_reset", bus.sys_reset, 1);
        check("t3_e23_ready", bus.ready, 0);
        for (int e = 24; e <= 35; e++) begin
            step();
            check("t3_restart_held", bus.sys_reset, 1);
        end
        step();
        check("t3_e36_sys_reset", bus.sys_reset, 0);
        check("t3_e36_ready", bus.ready, 1);
`ifdef PLL_LOSS_COUNT_EN
        check("t3_losses", bus.lock_losses, 1);
`endif

        // 4: glitch during STABILIZE after edge 6 -> release at edge 22
        reset = 1'b1;
        step();
        check("t4_reset", bus.sys_reset, 1);
        reset = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            step();
            check("t4_pre", bus.sys_reset, 1);
        end
        bus.pll_locked = 1'b0;
        step();
        bus.pll_locked = 1'b1;
        check("t4_e7", bus.sys_reset, 1);
        for (int e = 8; e <= 21; e++) begin
            step();
            check("t4_held", bus.sys_reset, 1);
        end
        step();
        check("t4_e22_sys_reset", bus.sys_reset, 0);
        check("t4_e22_ready", bus.ready, 1);
`ifdef PLL_LOSS_COUNT_EN
        check("t4_losses", bus.lock_losses, 0);
`endif

        // 5: reset and lock loss together in RUN
        step();
        step();
        check("t5_run", bus.sys_reset, 0);
        reset          = 1'b1;
        bus.pll_locked = 1'b0;
        step();
        check("t5_sys_reset", bus.sys_reset, 1);
        check("t5_ready", bus.ready, 0);
`ifdef PLL_LOSS_COUNT_EN
        check("t5_losses", bus.lock_losses, 0);
`endif
        step();
        check("t5_sys_reset_2", bus.sys_reset, 1);

`ifdef PLL_LOSS_COUNT_EN
        // 6: 300 losses from RUN saturate the counter
        bus.pll_locked = 1'b1;
        reset          = 1'b0;
        repeat (15) step();
        check("t6_run", bus.sys_reset, 0);
        for (int k = 1; k <= 300; k++) begin
            bus.pll_locked = 1'b0;
            step();
            bus.pll_locked = 1'b1;
            repeat (15) step();
            if (k == 10)  check("t6_losses_10", bus.lock_losses, 10);
            if (k == 254) check("t6_losses_254", bus.lock_losses, 254);
            if (k == 255) check("t6_losses_255", bus.lock_losses, 255);
        end
        check("t6_run_end", bus.sys_reset, 0);
        check("t6_losses_sat", bus.lock_losses, 255);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
